mux_scan_sequencer: RTL and testbench

- Upstream/downstream companion of the team's 4:1 mux (select inputs s1,s0; data output out).
- Drives s1,s0 through all four channels and waits a programmable settle time on each. Samples the mux output and assembles the four bits into one word with a one-cycle valid strobe.
- Converts four slow single-bit sources into a parallel word through a single mux path.

---
 rtl/mux_scan_pkg.sv | 18 +
 rtl/scan_dwell_counter.sv | 48 ++++
 rtl/mux_scan_sequencer.sv | 155 +++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the mux scan sequencer: FSM state encoding, channel
// count and select width.
// -----------------------------------------------------------------------------
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage : mux_scan_pkg

// File: rtl/scan_dwell_counter.sv
// -----------------------------------------------------------------------------
// scan_dwell_counter
// CNT_W-bit up counter that times the settle interval on each mux channel.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (clears the count)
//   clear_i  synchronous clear, has priority over enable_i
//   enable_i count up by one this cycle
//   term_o   high while the count equals DWELL-1 (last settle cycle)
// -----------------------------------------------------------------------------
module scan_dwell_counter #(
  parameter int CNT_W = 3,
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic term_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over enable, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == CNT_W'(DWELL - 1));

endmodule : scan_dwell_counter

// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
// Walks the select lines of an external 4:1 mux through channels 0..3, waits
// DWELL settle cycles on each, samples mux_out once per channel and publishes
// the four bits as one word with a single-cycle valid strobe.
//
// Parameters:
//   DWELL  settle cycles per channel, legal range 1..(2**CNT_W - 1)
//   CNT_W  width of the dwell counter
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    scan request, only looked at in IDLE
//   mux_out  data output of the 4:1 mux (synchronous to clk)
//   s0, s1   registered mux select, {s1,s0} = current channel
//   word     assembled result, word[i] = mux_out sampled on channel i
//   valid    one-cycle strobe, coincident with the word update
//   busy     high while a scan is in progress
//
// Build option:
//   MUX_SCAN_CONTINUOUS_EN  when defined, DONE loops straight back to SETTLE on
//                           channel 0 so scanning repeats forever after the
//                           first start; only rst returns the block to IDLE.
// -----------------------------------------------------------------------------
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic [3:0] word,
  output logic       valid,
  output logic       busy
);

  state_e              state_q;
  state_e              state_d;
  logic [SEL_W-1:0]    sel_q;
  logic [SEL_W-1:0]    sel_d;
  logic [NUM_CH-1:0]   shadow_q;
  logic [NUM_CH-1:0]   shadow_d;
  logic [NUM_CH-1:0]   word_q;
  logic [NUM_CH-1:0]   word_d;
  logic                valid_q;
  logic                valid_d;
  logic                busy_q;
  logic                busy_d;
  logic                dwell_done_s;

  // The counter only runs in SETTLE; every other state holds it at zero so
  // each channel starts its settle interval from a clean count.
  scan_dwell_counter #(
    .CNT_W (CNT_W),
    .DWELL (DWELL)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q != SETTLE),
    .enable_i (state_q == SETTLE),
    .term_o   (dwell_done_s)
  );

  // Next-state, select, shadow and registered-output logic.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (dwell_done_s) begin
          state_d = SAMPLE;
        end else begin
          state_d = SETTLE;
        end
      end
      SAMPLE: begin
        shadow_d[sel_q] = mux_out;
        if (sel_q == SEL_W'(NUM_CH - 1)) begin
          // Select stays on the last channel through DONE.
          state_d = DONE;
        end else begin
          sel_d   = sel_q + {{(SEL_W-1){1'b0}}, 1'b1};
          state_d = SETTLE;
        end
      end
      DONE: begin
        sel_d = '0;
`ifdef MUX_SCAN_CONTINUOUS_EN
        state_d = SETTLE;
`else
        state_d = IDLE;
`endif
      end
      default: begin
        sel_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so valid and the new word
    // appear together in the DONE cycle itself.
    valid_d = (state_d == DONE);
    if (state_d == DONE) begin
      word_d = shadow_d;
    end else begin
      word_d = word_q;
    end
`ifdef MUX_SCAN_CONTINUOUS_EN
    busy_d = (state_d != IDLE);
`else
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
`endif
  end

  // State, select, shadow and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign s0    = sel_q[0];
  assign s1    = sel_q[1];
  assign word  = word_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule : mux_scan_sequencer

// File: tb/tb_mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_sequencer
// Two sequencers (DWELL=4 and DWELL=1), each feeding a behavioural 4:1 mux.
// A reference model tracks each scan as "cycles since accept" and derives the
// expected select, busy, valid and word from that position every cycle.
// Honours MUX_SCAN_CONTINUOUS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_mux_scan_sequencer;

`ifdef MUX_SCAN_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic [3:0] da;
  logic [3:0] db;

  logic       s0_a, s1_a, valid_a, busy_a, mux_a;
  logic [3:0] word_a;
  logic       s0_b, s1_b, valid_b, busy_b, mux_b;
  logic [3:0] word_b;

  int checks   = 0;
  int failures = 0;

  // Reference model state per instance.
  int         m_pos[2];
  logic [3:0] m_shadow[2];
  logic [3:0] m_word[2];
  int         dw[2];

  always #5 clk = ~clk;

  assign mux_a = da[{s1_a, s0_a}];
  assign mux_b = db[{s1_b, s0_b}];

  mux_scan_sequencer #(.DWELL(4), .CNT_W(3)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .mux_out(mux_a),
    .s0(s0_a), .s1(s1_a), .word(word_a), .valid(valid_a), .busy(busy_a)
  );

  mux_scan_sequencer #(.DWELL(1), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .mux_out(mux_b),
    .s0(s0_b), .s1(s1_b), .word(word_b), .valid(valid_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k]    = 0;
      m_shadow[k] = 4'b0000;
      m_word[k]   = 4'b0000;
    end
  endtask

  // Advance the model across one clock edge using the pre-edge inputs.
  task automatic model_edge();
    int p, len, ch;
    logic [3:0] dv;
    for (int k = 0; k < 2; k++) begin
      p   = m_pos[k];
      len = 4 * (dw[k] + 1);
      dv  = (k == 0) ? da : db;
      if (rst) begin
        m_pos[k] = 0; m_shadow[k] = 4'b0000; m_word[k] = 4'b0000;
      end else if (p == 0) begin
        m_pos[k] = start[k] ? 1 : 0;
      end else if (p <= len) begin
        ch = (p - 1) / (dw[k] + 1);
        // Last cycle of each channel's slot is the sampling cycle.
        if (((p - 1) % (dw[k] + 1)) == dw[k]) m_shadow[k][ch] = dv[ch];
        m_pos[k] = p + 1;
        if (p + 1 == len + 1) m_word[k] = m_shadow[k];
      end else begin
        m_pos[k] = CONT ? 1 : 0;
      end
    end
  endtask

  task automatic check_inst(input int k, input logic [3:0] w, input logic v,
                            input logic b, input logic [1:0] s, input string tag);
    int p, len;
    logic [1:0] es;
    p   = m_pos[k];
    len = 4 * (dw[k] + 1);
    if (p == 0)            es = 2'd0;
    else if (p == len + 1) es = 2'd3;
    else                   es = 2'((p - 1) / (dw[k] + 1));
    chk($sformatf("%s_k%0d_word", tag, k), {28'd0, w}, {28'd0, m_word[k]});
    chk($sformatf("%s_k%0d_valid", tag, k), {31'd0, v}, {31'd0, (p == len + 1)});
    chk($sformatf("%s_k%0d_busy", tag, k), {31'd0, b},
        {31'd0, (CONT ? (p != 0) : (p >= 1 && p <= len))});
    chk($sformatf("%s_k%0d_sel", tag, k), {30'd0, s}, {30'd0, es});
  endtask

  task automatic check_all(input string tag);
    check_inst(0, word_a, valid_a, busy_a, {s1_a, s0_a}, tag);
    check_inst(1, word_b, valid_b, busy_b, {s1_b, s0_b}, tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
  endtask

  // Raise rst mid-cycle, check the outputs clear at once, hold two edges.
  task automatic async_reset();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Pulse start on instance k and wait (bounded) for valid; n counts edges
  // with the accepting edge as 1, so DWELL=4 expects 21.
  task automatic run_scan(input int k, input int exp_n, input logic [3:0] exp_word,
                          input int repulse_at, input string tag);
    int  n;
    bit  seen;
    n = 0; seen = 1'b0;
    start[k] = 1'b1;
    while (!seen && n < 80) begin
      tick();
      n++;
      start[k] = (repulse_at != 0 && n == repulse_at) ? 1'b1 : 1'b0;
      seen = (k == 0) ? valid_a : valid_b;
    end
    start[k] = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(exp_n));
    chk({tag, "_word"}, {28'd0, (k == 0) ? word_a : word_b}, {28'd0, exp_word});
  endtask

  initial begin
    dw[0] = 4; dw[1] = 1;
    rst = 1'b1; start = 2'b00; da = 4'b0000; db = 4'b0000;
    model_reset();
    #1;
    check_all("por");
    tick();
    tick();
    rst = 1'b0;

    // Reset mid-cycle, then idle with no start.
    async_reset();
    repeat (50) tick();

    // Basic scan with d3..d0 = 1,0,1,1 and a stray start during the scan.
    da = 4'b1011;
    run_scan(0, 21, 4'b1011, 7, "basic");
`ifndef MUX_SCAN_CONTINUOUS_EN
    repeat (8) tick();
    da = 4'b0110;
    run_scan(0, 21, 4'b0110, 0, "second");

    // Abort mid-scan, no valid afterwards, then a fresh scan.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (11) tick();
    async_reset();
    repeat (40) tick();
    run_scan(0, 21, 4'b0110, 0, "post_rst");
`else
    // Repeating scans: next valid 21 cycles later, new data picked up.
    da = 4'b0101;
    run_scan(0, 21, 4'b0101, 0, "cont2");
    run_scan(0, 21, 4'b0101, 0, "cont3");
`endif

    // Minimum dwell on the DWELL=1 instance.
    db = 4'b1000;
    run_scan(1, 9, 4'b1000, 0, "min_dwell");

    // Random data and start pulses, checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) da = 4'($urandom);
      if ($urandom_range(0, 15) == 0) db = 4'($urandom);
      start[0] = ($urandom_range(0, 9) == 0);
      start[1] = ($urandom_range(0, 5) == 0);
      if (i == 300) async_reset();
      tick();
    end
    start = 2'b00;
    repeat (25) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_scan_sequencer
